sr_latch_driver: RTL and testbench

//  Clocked front-end that feeds the gate-level SR latch stage (s, r -> q). It turns single-bit

---
 rtl/sr_latch_pkg.sv | 19 +
 rtl/sr_pulse_timer.sv | 25 ++
 rtl/sr_latch_driver.sv | 135 +++++++++++++
 tb/tb_sr_latch_driver.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/sr_latch_pkg.sv
// Shared types and {s,r} drive codes for the SR latch front-end.
package sr_latch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    RECOVER
  } sr_drv_state_t;

  // Bit order is {s, r}; 2'b00 is the unused latch code and never appears here.
  localparam logic [1:0] SR_HOLD  = 2'b11;
  localparam logic [1:0] SR_SET   = 2'b10;
  localparam logic [1:0] SR_CLEAR = 2'b01;

  function automatic logic [1:0] write_pattern(input logic value);
    return value ? SR_SET : SR_CLEAR;
  endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter; expire is high in the last cycle of a loaded interval.
module sr_pulse_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  // NOTE: count has no reset of its own; the parent asserts load during reset,
  // so the value is defined from the first reset edge onward.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked valid/ready front-end producing timed set/clear strobes for an SR latch.
// Optional readback check enabled by defining SR_LATCH_DRIVER_CHECK_EN.
module sr_latch_driver #(
  parameter int PULSE_CYCLES   = 2,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_value,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic q_shadow,
  output logic busy,
  output logic done,
  output logic err
);

  import sr_latch_pkg::*;

  if (PULSE_CYCLES < 1) begin : g_bad_pulse
    $error("PULSE_CYCLES must be >= 1");
  end
  if (RECOVER_CYCLES < 1) begin : g_bad_recover
    $error("RECOVER_CYCLES must be >= 1");
  end

  localparam int CNT_MAX = (PULSE_CYCLES > RECOVER_CYCLES) ? PULSE_CYCLES : RECOVER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD   = CNT_W'(PULSE_CYCLES);
  localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_CYCLES);

  sr_drv_state_t    state, state_next;
  logic [1:0]       sr_q, sr_next;
  logic             load_req, expire, done_next, check_now, wrote, accept;
  logic [CNT_W-1:0] load_val;

  sr_pulse_timer #(.WIDTH(CNT_W)) u_timer (
    .clk      (clk),
    .load     (rst | load_req),
    .load_val (rst ? RECOVER_LOAD : load_val),
    .expire   (expire)
  );

  assign accept = (state == IDLE) && req_valid;

  // NOTE: every state element uses non-blocking assignment so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= RECOVER;
    else     state <= state_next;
  end

  // NOTE: all outputs of this block get a default first, so no path infers a latch.
  always_comb begin
    state_next = state;
    sr_next    = sr_q;
    load_req   = 1'b0;
    load_val   = RECOVER_LOAD;
    done_next  = 1'b0;
    check_now  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_next = PULSE;
          load_req   = 1'b1;
          load_val   = PULSE_LOAD;
          sr_next    = write_pattern(req_value);
        end
      end
      PULSE: begin
        if (expire) begin
          state_next = RECOVER;
          load_req   = 1'b1;
          sr_next    = SR_HOLD;
        end
      end
      RECOVER: begin
        // Entered from reset with the clear code still driven: the hold
        // interval starts only once s=r=1 is actually presented.
        if (sr_q != SR_HOLD) begin
          load_req = 1'b1;
          sr_next  = SR_HOLD;
        end else if (expire) begin
          state_next = IDLE;
          done_next  = wrote;
          check_now  = wrote;
        end
      end
      default: begin
        state_next = RECOVER;
        load_req   = 1'b1;
        sr_next    = SR_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q     <= SR_CLEAR;
      q_shadow <= 1'b0;
      done     <= 1'b0;
      wrote    <= 1'b0;
    end else begin
      sr_q <= sr_next;
      done <= done_next;
      if (accept) begin
        q_shadow <= req_value;
        wrote    <= 1'b1;
      end
    end
  end

  assign s         = sr_q[1];
  assign r         = sr_q[0];
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifdef SR_LATCH_DRIVER_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (check_now && (q_fb != q_shadow)) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ check_now;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench: two driver instances (default and PULSE=1/RECOVER=3) against a timeline model.
module tb_sr_latch_driver;

  localparam int PA = 2, RA = 1;
  localparam int PB = 1, RB = 3;
`ifdef SR_LATCH_DRIVER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, req_valid, req_value, fb_a, fb_b;
  logic rdy_a, s_a, r_a, sh_a, busy_a, done_a, err_a;
  logic rdy_b, s_b, r_b, sh_b, busy_b, done_b, err_b;

  always #5 clk = ~clk;

  sr_latch_driver #(.PULSE_CYCLES(PA), .RECOVER_CYCLES(RA)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_a), .req_value(req_value),
    .s(s_a), .r(r_a), .q_fb(fb_a), .q_shadow(sh_a), .busy(busy_a), .done(done_a), .err(err_a)
  );

  sr_latch_driver #(.PULSE_CYCLES(PB), .RECOVER_CYCLES(RB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_b), .req_value(req_value),
    .s(s_b), .r(r_b), .q_fb(fb_b), .q_shadow(sh_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: the edge of the most recent reset or acceptance fixes the whole timeline.
  typedef struct {
    int last_rst;
    int acc;
    bit shadow;
    bit err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic bit m_write(mdl_t m);
    return m.acc > m.last_rst;
  endfunction

  function automatic int m_d(mdl_t m, int e);
    return e - (m_write(m) ? m.acc : m.last_rst);
  endfunction

  function automatic bit m_idle(mdl_t m, int e, int p, int rc);
    if (m_write(m)) return m_d(m, e) >= p + rc;
    return m_d(m, e) >= rc + 1;
  endfunction

  function automatic logic [1:0] m_sr(mdl_t m, int e, int p);
    if (m_write(m)) return (m_d(m, e) < p) ? (m.shadow ? 2'b10 : 2'b01) : 2'b11;
    return (m_d(m, e) == 0) ? 2'b01 : 2'b11;
  endfunction

  function automatic bit m_done(mdl_t m, int e, int p, int rc);
    return m_write(m) && (m_d(m, e) == p + rc);
  endfunction

  function automatic mdl_t m_edge(mdl_t m, int e, int p, int rc,
                                  bit rst_i, bit v, bit val, bit fb);
    mdl_t n;
    n = m;
    if (rst_i) begin
      n.last_rst = e;
      n.shadow   = 1'b0;
      n.err      = 1'b0;
    end else begin
      if (m_write(m) && (m_d(m, e - 1) == p + rc - 1) && (fb != m.shadow))
        n.err = n.err | CHECK_EN;
      if (m_idle(m, e - 1, p, rc) && v) begin
        n.acc    = e;
        n.shadow = val;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic s_i, input logic r_i,
                           input logic rdy, input logic bsy, input logic dn,
                           input logic sh, input logic er, input mdl_t m,
                           input int p, input int rc);
    bit idle;
    idle = m_idle(m, edge_n, p, rc);
    check({nm, ".sr"},       {s_i, r_i},           m_sr(m, edge_n, p));
    check({nm, ".never00"},  {1'b0, s_i | r_i},    2'b01);
    check({nm, ".ready"},    {1'b0, rdy},          {1'b0, idle});
    check({nm, ".busy"},     {1'b0, bsy},          {1'b0, !idle});
    check({nm, ".done"},     {1'b0, dn},           {1'b0, m_done(m, edge_n, p, rc)});
    check({nm, ".q_shadow"}, {1'b0, sh},           {1'b0, m.shadow});
    check({nm, ".err"},      {1'b0, er},           {1'b0, m.err});
  endtask

  // fbm: 0 = q_fb forced low, 2 = q_fb follows the written value, 3 = occasionally wrong
  task automatic step(input bit rst_i, input bit v, input bit val, input int fbm);
    rst       = rst_i;
    req_valid = v;
    req_value = val;
    case (fbm)
      0:       begin fb_a = 1'b0;      fb_b = 1'b0;      end
      3:       begin
                 fb_a = ma.shadow ^ ($urandom_range(7) == 0);
                 fb_b = mb.shadow ^ ($urandom_range(7) == 0);
               end
      default: begin fb_a = ma.shadow; fb_b = mb.shadow; end
    endcase
    @(posedge clk);
    edge_n++;
    ma = m_edge(ma, edge_n, PA, RA, rst_i, v, val, fb_a);
    mb = m_edge(mb, edge_n, PB, RB, rst_i, v, val, fb_b);
    #1;
    check_dut("a", s_a, r_a, rdy_a, busy_a, done_a, sh_a, err_a, ma, PA, RA);
    check_dut("b", s_b, r_b, rdy_b, busy_b, done_b, sh_b, err_b, mb, PB, RB);
  endtask

  initial begin
    ma = '{last_rst: 0, acc: -1000, shadow: 1'b0, err: 1'b0};
    mb = ma;
    rst = 1'b1; req_valid = 1'b0; req_value = 1'b0; fb_a = 1'b0; fb_b = 1'b0;

    // Reset for two cycles, release, then settle into IDLE without a done.
    step(1, 0, 0, 2);
    step(1, 1, 1, 2);
    repeat (6) step(0, 0, 0, 2);

    // Single set request followed by idle.
    step(0, 1, 1, 2);
    repeat (7) step(0, 0, 0, 2);

    // req_valid held high, value 1 then 0: back-to-back acceptance in the done cycle.
    step(0, 1, 1, 2);
    repeat (11) step(0, 1, 0, 2);
    repeat (6) step(0, 0, 0, 2);

    // Clear request, reset during its second PULSE cycle.
    step(0, 1, 0, 2);
    step(0, 0, 0, 2);
    step(1, 0, 0, 2);
    repeat (6) step(0, 0, 0, 2);

    // Set with q_fb stuck low: err only when the check is built in, sticky until reset.
    step(0, 1, 1, 0);
    repeat (10) step(0, 0, 0, 0);
    step(0, 1, 1, 2);
    repeat (6) step(0, 0, 0, 2);
    step(1, 0, 0, 2);
    repeat (6) step(0, 0, 0, 2);

    // Idempotent rewrite of the same value.
    step(0, 1, 0, 2);
    repeat (6) step(0, 1, 0, 2);
    repeat (6) step(0, 0, 0, 2);

    // Randomized traffic with occasional resets and readback mismatches.
    repeat (400) begin
      step($urandom_range(39) == 0, $urandom_range(2) != 0, 1'($urandom), 3);
    end
    repeat (6) step(0, 0, 0, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
